// File: rtl/serial_addsub_ctrl.sv
// rtl/serial_addsub_ctrl.sv - bit-serial add/subtract sequencer with ALU flags

module fullAdder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sel,
    output logic sum,
    output logic cout
);
    logic bx;

    assign bx   = b ^ sel;
    assign sum  = a ^ bx ^ cin;
    assign cout = (a & bx) | (cin & (a ^ bx));
endmodule

module serial_addsub_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    count;
    logic             carry;
    logic             sum_bit;
    logic             cout;
    logic [WIDTH-1:0] res_next;

    // Subtraction is a + ~b + 1: b is inverted at load and carry seeded with 1.
    fullAdder_1bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sel  (1'b0),
        .sum  (sum_bit),
        .cout (cout)
    );

    assign res_next = {sum_bit, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            count     <= '0;
            carry     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= sub ? ~b : b;
                        carry     <= sub;
                        count     <= '0;
                        res_sh    <= '0;
                        result    <= '0;
                        carry_out <= 1'b0;
                        overflow  <= 1'b0;
                        zero      <= 1'b0;
                        negative  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= cout;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        // carry still holds the carry into the MSB on this cycle
                        result    <= res_next;
                        carry_out <= cout;
                        overflow  <= carry ^ cout;
                        zero      <= (res_next == '0);
                        negative  <= res_next[WIDTH-1];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb/tb_serial_addsub_ctrl.sv - table-driven bench for serial_addsub_ctrl at WIDTH 8 and 64

module tb_serial_addsub_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, start8, sub8, busy8, done8, c8, v8, z8, n8;
    logic [7:0]  a8, b8, result8;
    logic        rst64, start64, sub64, busy64, done64, c64, v64, z64, n64;
    logic [63:0] a64, b64, result64;

    int total = 0;
    int passed = 0;

    serial_addsub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .carry_out(c8),
        .overflow(v8), .zero(z8), .negative(n8)
    );

    serial_addsub_ctrl #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(rst64), .start(start64), .sub(sub64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .result(result64), .carry_out(c64),
        .overflow(v64), .zero(z64), .negative(n64)
    );

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flags;  // {carry, overflow, zero, negative}
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_done(input bit wide, output int bc, output bit got, output bit ovl);
        bc = 0; got = 0; ovl = 0;
        for (int i = 0; i < 200; i++) begin
            if ((wide ? busy64 : busy8) && (wide ? done64 : done8)) ovl = 1;
            if (wide ? done64 : done8) begin
                got = 1;
                break;
            end
            if (wide ? busy64 : busy8) bc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input bit wide, input logic [63:0] av, input logic [63:0] bv,
                          input logic sv, output logic [63:0] res, output logic [3:0] fl,
                          output int bc, output bit got, output bit ovl, output logic done_after);
        @(negedge clk);
        if (wide) begin a64 = av; b64 = bv; sub64 = sv; start64 = 1'b1; end
        else begin a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv; start8 = 1'b1; end
        @(negedge clk);
        start8 = 1'b0; start64 = 1'b0;
        wait_done(wide, bc, got, ovl);
        res = wide ? result64 : {56'b0, result8};
        fl  = wide ? {c64, v64, z64, n64} : {c8, v8, z8, n8};
        @(negedge clk);
        done_after = wide ? done64 : done8;
    endtask

    function automatic void model64(input logic [63:0] av, input logic [63:0] bv, input logic sv,
                                    output logic [63:0] res, output logic [3:0] fl);
        logic [64:0] s;
        logic c, v;
        if (sv) begin
            res = av - bv;
            c = (av >= bv);
            v = (av[63] != bv[63]) && (res[63] != av[63]);
        end else begin
            s = {1'b0, av} + {1'b0, bv};
            res = s[63:0];
            c = s[64];
            v = (av[63] == bv[63]) && (res[63] != av[63]);
        end
        fl = {c, v, (res == 64'd0), res[63]};
    endfunction

    vec_t vecs[$];
    logic [63:0] res, eres, ra, rb;
    logic [3:0] fl, efl;
    logic rs, dafter;
    int bc, dcount;
    bit got, ovl;

    initial begin
        vecs.push_back('{1'b0, 8'h05, 8'h03, 8'h08, 4'b0000});
        vecs.push_back('{1'b0, 8'h7F, 8'h01, 8'h80, 4'b0101});
        vecs.push_back('{1'b0, 8'hFF, 8'h01, 8'h00, 4'b1010});
        vecs.push_back('{1'b1, 8'h05, 8'h05, 8'h00, 4'b1010});
        vecs.push_back('{1'b1, 8'h03, 8'h05, 8'hFE, 4'b0001});
        vecs.push_back('{1'b1, 8'h80, 8'h01, 8'h7F, 4'b1100});
        vecs.push_back('{1'b1, 8'h00, 8'h00, 8'h00, 4'b1010});
        vecs.push_back('{1'b0, 8'h80, 8'h80, 8'h00, 4'b1110});

        rst8 = 1'b1; rst64 = 1'b1;
        start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
        start64 = 0; sub64 = 0; a64 = 0; b64 = 0;
        #1;
        chk("reset8_outputs", {busy8, done8, result8, c8, v8, z8, n8}, 64'd0);
        chk("reset64_outputs", {busy64, done64, c64, v64, z64, n64}, 64'd0);
        chk("reset64_result", result64, 64'd0);
        @(negedge clk); @(negedge clk);
        rst8 = 1'b0; rst64 = 1'b0;

        foreach (vecs[i]) begin
            run_op(0, {56'b0, vecs[i].a}, {56'b0, vecs[i].b}, vecs[i].sub, res, fl, bc, got, ovl, dafter);
            chk($sformatf("v%0d_busy_cycles", i), bc, 8);
            chk($sformatf("v%0d_done_seen", i), got, 1);
            chk($sformatf("v%0d_result", i), res, {56'b0, vecs[i].res});
            chk($sformatf("v%0d_flags", i), fl, vecs[i].flags);
            chk($sformatf("v%0d_done_one_cycle", i), {dafter, ovl}, 0);
        end

        // start held high through RUN, operands changed mid-operation, back-to-back accept in DONE
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h03; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h02;
        wait_done(0, bc, got, ovl);
        chk("b2b_first_busy", bc, 8);
        chk("b2b_first_done", got, 1);
        chk("b2b_first_result", result8, 8'h08);
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_restart_busy", {busy8, done8}, 2'b10);
        wait_done(0, bc, got, ovl);
        chk("b2b_second_busy", bc, 8);
        chk("b2b_second_done", got, 1);
        chk("b2b_second_result", result8, 8'h42);
        chk("b2b_no_overlap", ovl, 0);
        @(negedge clk);

        // asynchronous reset mid-RUN aborts without a done pulse
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h03; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("midrun_busy_before_reset", busy8, 1);
        #2 rst8 = 1'b1;
        #1;
        chk("midrun_reset_outputs", {busy8, done8, result8, c8, v8, z8, n8}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst8 = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) dcount++;
        end
        chk("midrun_no_done_after_reset", dcount, 0);
        run_op(0, 64'h0A, 64'h05, 1'b0, res, fl, bc, got, ovl, dafter);
        chk("after_reset_result", res, 64'h0F);
        chk("after_reset_busy", bc, 8);

        // WIDTH=64 boundary and randomized compare
        run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, res, fl, bc, got, ovl, dafter);
        chk("w64_busy_cycles", bc, 64);
        chk("w64_done_seen", got, 1);
        chk("w64_result", res, 64'd0);
        chk("w64_flags", fl, 4'b1010);

        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rb = (i % 7 == 0) ? ra : {$urandom, $urandom};
            rs = $urandom_range(0, 1);
            model64(ra, rb, rs, eres, efl);
            run_op(1, ra, rb, rs, res, fl, bc, got, ovl, dafter);
            chk($sformatf("rand%0d_result", i), res, eres);
            chk($sformatf("rand%0d_flags", i), fl, efl);
            chk($sformatf("rand%0d_timing", i), {bc, got, ovl, dafter}, {32'd64, 1'b1, 1'b0, 1'b0});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
